tdm_demux_8: RTL
================

# tdm_demux_8

Registered 8-way time-division demultiplexer: it accepts a serial stream of WIDTH-bit samples, one per slot, with a frame-sync marker on slot 0. It assembles each 8-slot frame and presents all eight samples in parallel on lanes d0..d7 with a one-cycle frame strobe. It is the receive-side counterpart of the 8:1 mux: it undoes the slot selection that the mux performs on select `s`, and it sits between a serial link and parallel consumers.

## Interface
- WIDTH, default 3, bit width of each sample and of each output lane.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  din/sync carry a sample this cycle.
- sync  in  1  qualified by in_valid; marks din as slot 0 of a frame.
- din  in  WIDTH  sample data.
- d0..d7  out  WIDTH each  registered lanes holding the last complete frame, slot k on dk.
- frame_valid  out  1  one-cycle pulse when d0..d7 update.
- frame_err  out  1  one-cycle pulse on a framing violation.
- s  out  3  slot index the next accepted sample will fill.
- locked  out  1  high in state RUN.

## Operation
- A sample is accepted on a rising clk edge when in_valid=1. When in_valid=0, all state holds and no pulses are generated.
- States:
  - HUNT: reset state. Accepted samples with sync=0 are discarded. An accepted sample with sync=1 is stored in shadow slot 0, sets s=1, and moves the block to RUN.
  - RUN, sync=0 with s in 1..7: store din in shadow[s] and increment s. When s was 7, copy shadow[0..6] and din into d0..d7, pulse frame_valid, and wrap s to 0.
  - RUN, s=0: sync=1 starts the next frame (store slot 0, s=1). sync=0 pulses frame_err, discards the sample, returns to HUNT, and keeps s=0.
  - RUN, sync=1 with s≠0 (early sync): pulse frame_err, discard the partial frame, store din as slot 0, set s=1, and stay in RUN.
- d0..d7 change only on frame completion. A partial or errored frame never reaches the outputs.
- frame_valid and frame_err are never high in the same cycle.

## Timing
- Reset (rst_n=0, asynchronous): state=HUNT, s=0, locked=0, d0..d7=0, shadow=0, frame_valid=0, frame_err=0.
- Latency: d0..d7 and frame_valid update on the same edge that accepts slot 7, so the frame is visible immediately after that edge.
- Minimum frame period is 8 cycles with in_valid held high. Back-to-back frames give frame_valid exactly every 8 cycles with no gap.
- Gaps in in_valid at any slot stretch the frame. Contents are unaffected.
- Pulses last exactly one cycle even if in_valid drops on the following cycle.
- rst_n asserted mid-frame aborts the frame. No frame_valid is generated for it, and outputs clear immediately.
- After rst_n deasserts, the first edge behaves as in HUNT.

## Structure
- Shared package `tdm_pkg` holds:
  - NUM_SLOTS=8 and SLOT_W=3.
  - A state enum {HUNT, RUN}.
  - This package is shared with the future TDM transmitter.
- One natural sub-module, `tdm_slot_cnt`: a 3-bit slot counter with increment/load-1/clear controls and a wrap flag.
- Everything else lives in the top module: FSM, shadow registers, and output registers.

## Test plan
- Reset then clean frame: in_valid=1, sync on first sample, din=0..7 (WIDTH=3) → after 8th edge d0..d7=0..7, frame_valid for 1 cycle, s=0, locked=1.
- Hunt discard: three samples with sync=0, then a frame of din=7,6,5,4,3,2,1,0 → leading samples ignored; d0=7 … d7=0; locked rises on the sync edge.
- Early sync: sync at slot 4 with din=5, then 7 more samples 1..7 → frame_err pulse at slot 4; no frame_valid for the partial frame; next frame_valid shows d0=5, d1..d7=1..7.
- Missing sync: frame completes, then the next sample arrives with sync=0 → frame_err, locked=0, state HUNT, and d0..d7 keep the previous frame.
- Stalls: a frame with in_valid low for 3 cycles at slots 2 and 6 → same d0..d7 as the unstalled frame, frame_valid once, s holds during stalls.
- Reset mid-frame: rst_n low after slot 5 → outputs 0 at once, then the frame after release is captured correctly.

Source files
------------

// File: rtl/tdm_pkg.sv
// tdm_pkg
// Shared definitions for the TDM receive path. The future TDM transmitter
// imports these as well.
//   NUM_SLOTS   : slots per frame
//   SLOT_W      : width of a slot index
//   tdm_state_e : framing state (HUNT = searching for sync, RUN = locked)
package tdm_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int SLOT_W    = 3;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } tdm_state_e;

endpackage : tdm_pkg

// File: rtl/tdm_slot_cnt.sv
// tdm_slot_cnt
// Slot index counter for the TDM demultiplexer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : advance to the next slot, wrapping from the last slot to 0
//   load1      : force the index to 1 (slot 0 has just been taken)
//   clr        : force the index to 0 (highest priority)
//   cnt        : current slot index
//   wrap       : high while cnt is the last slot, so the next inc wraps
module tdm_slot_cnt
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              load1,
  input  logic              clr,
  output logic [SLOT_W-1:0] cnt,
  output logic              wrap
);

  logic [SLOT_W-1:0] cnt_q;
  logic [SLOT_W-1:0] cnt_d;

  // The slot count is a power of two, so the plain increment wraps by itself.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load1) begin
      cnt_d = SLOT_W'(1);
    end else if (inc) begin
      cnt_d = cnt_q + SLOT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = (cnt_q == SLOT_W'(NUM_SLOTS - 1));

endmodule : tdm_slot_cnt

// File: rtl/tdm_demux_8.sv
// tdm_demux_8
// Registered 8-way TDM demultiplexer. Serial samples are collected into a
// shadow frame and the whole frame is presented on d0..d7 at once when slot 7
// arrives. Partial or errored frames never reach the outputs.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : din/sync carry a sample this cycle
//   sync        : marks din as slot 0 (qualified by in_valid)
//   din         : sample data
//   d0..d7      : last complete frame, slot k on dk
//   frame_valid : one-cycle pulse when d0..d7 update
//   frame_err   : one-cycle pulse on a framing violation
//   s           : slot the next accepted sample will fill
//   locked      : high while in RUN
module tdm_demux_8
  import tdm_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              sync,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  d0,
  output logic [WIDTH-1:0]  d1,
  output logic [WIDTH-1:0]  d2,
  output logic [WIDTH-1:0]  d3,
  output logic [WIDTH-1:0]  d4,
  output logic [WIDTH-1:0]  d5,
  output logic [WIDTH-1:0]  d6,
  output logic [WIDTH-1:0]  d7,
  output logic              frame_valid,
  output logic              frame_err,
  output logic [2:0]        s,
  output logic              locked
);

  tdm_state_e        state_q, state_d;
  logic [WIDTH-1:0]  shadow_q [NUM_SLOTS];
  logic [WIDTH-1:0]  shadow_d [NUM_SLOTS];
  logic [WIDTH-1:0]  lanes_q  [NUM_SLOTS];
  logic [WIDTH-1:0]  lanes_d  [NUM_SLOTS];
  logic              frame_valid_q, frame_valid_d;
  logic              frame_err_q, frame_err_d;

  logic              cnt_inc, cnt_load1, cnt_clr;
  logic [SLOT_W-1:0] slot;
  logic              slot_last;

  tdm_slot_cnt u_slot_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_inc),
    .load1 (cnt_load1),
    .clr   (cnt_clr),
    .cnt   (slot),
    .wrap  (slot_last)
  );

  // An early sync does not need to scrub the shadow frame: every slot is
  // rewritten before the next completion, so stale entries can never leak.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    lanes_d       = lanes_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    cnt_inc       = 1'b0;
    cnt_load1     = 1'b0;
    cnt_clr       = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (sync) begin
            shadow_d[0] = din;
            cnt_load1   = 1'b1;
            state_d     = RUN;
          end
        end
        RUN: begin
          if (sync) begin
            frame_err_d = (slot != '0);
            shadow_d[0] = din;
            cnt_load1   = 1'b1;
          end else if (slot == '0) begin
            frame_err_d = 1'b1;
            cnt_clr     = 1'b1;
            state_d     = HUNT;
          end else begin
            shadow_d[slot] = din;
            cnt_inc        = 1'b1;
            if (slot_last) begin
              for (int k = 0; k < NUM_SLOTS - 1; k++) begin
                lanes_d[k] = shadow_q[k];
              end
              lanes_d[NUM_SLOTS-1] = din;
              frame_valid_d        = 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        shadow_q[k] <= '0;
        lanes_q[k]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      shadow_q      <= shadow_d;
      lanes_q       <= lanes_d;
    end
  end

  assign d0          = lanes_q[0];
  assign d1          = lanes_q[1];
  assign d2          = lanes_q[2];
  assign d3          = lanes_q[3];
  assign d4          = lanes_q[4];
  assign d5          = lanes_q[5];
  assign d6          = lanes_q[6];
  assign d7          = lanes_q[7];
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign s           = slot;
  assign locked      = (state_q == RUN);

endmodule : tdm_demux_8
